ext_ram_arbiter: RTL
====================

Name: ext_ram_arbiter

Overview:
- Shares the single byte-wide external SRAM between two 16-bit word requesters: the CPU-side port and a DMA/host port.
- Each granted word access runs as two byte phases, low byte then high byte, with a fixed per-byte cycle budget and a registered, glitch-free write strobe.
- Round-robin arbitration between the ports; req/ack handshake on each port.
- Sits between the memory controllers/DMA engine and the RAM pins at the top level.

Parameters:
- BYTE_CYCLES, 4: cycles per byte phase. Must be >= 3. Write pulse width = BYTE_CYCLES-2 cycles.
- ADDR_W, 18: word-address width. RAM byte address is ADDR_W+1 bits.

Ports:
- clock  in  1  system clock, ~50MHz
- reset_b  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU port request; held until cpu_ack
- cpu_rnw  in  1  1=read, 0=write; stable while cpu_req
- cpu_addr  in  ADDR_W  word address; stable while cpu_req
- cpu_wdata  in  16  write data; stable while cpu_req
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read word; valid from cpu_ack until the next CPU grant
- dma_req, dma_rnw, dma_addr, dma_wdata, dma_ack, dma_rdata: same as the cpu_* ports, for the DMA port
- ram_cs_b  out  1  RAM chip select, active low
- ram_oe_b  out  1  RAM output enable, active low
- ram_we_b  out  1  RAM write enable, active low, registered
- ram_addr  out  ADDR_W+1  {word address, a0}
- ram_data  inout  8  RAM data bus

Behaviour:
- States:
  - IDLE: arbitrate.
  - LO: byte a0=0.
  - HI: byte a0=1.
  - DONE: ack.
- Phase counter runs 0..BYTE_CYCLES-1 in LO and HI. LO->HI and HI->DONE on count = BYTE_CYCLES-1. DONE->IDLE unconditionally.
- Arbitration in IDLE:
  - One requester: grant it.
  - Both requesting: grant the port not granted last. last_grant resets to DMA, so the CPU wins the first tie.
  - Grant, rnw, addr and wdata are latched on the IDLE->LO edge. The address stays stable through both phases.
- ram_addr = {latched addr, a0}. a0 = 0 in LO, 1 in HI, 0 otherwise.
- ram_cs_b = 0 only in LO/HI.
- ram_oe_b = 0 only in LO/HI with a latched read.
- ram_we_b:
  - Flop output.
  - Low during phase counts 1..BYTE_CYCLES-2 of LO and HI, for writes only.
  - High at count 0 (address/data setup) and at count BYTE_CYCLES-1 (hold).
- ram_data:
  - Writes: driven with wdata[7:0] in LO and wdata[15:8] in HI.
  - Otherwise high-Z. Never driven during reads or in IDLE/DONE.
- Reads: the low byte is registered at the last LO cycle and the high byte at the last HI cycle. The granted port's rdata updates at the HI->DONE edge; the other port's rdata holds.
- The granted port's ack is high for exactly the DONE cycle. Its req is ignored in DONE; the requester drops req the cycle after ack.
- Latency: req seen in IDLE at cycle t gives ack at t+2*BYTE_CYCLES+1 (9 cycles for the default). Back-to-back throughput is one word per 2*BYTE_CYCLES+2 cycles.
- Simultaneous events:
  - A new req during LO/HI/DONE waits for IDLE.
  - Request changes during a transfer are ignored because the request is latched.
- Reset asserted at any time, including mid-phase:
  - State returns to IDLE and counter to 0.
  - ram_cs_b = ram_oe_b = ram_we_b = 1.
  - ram_data high-Z; both acks 0.
  - Both rdata = 0.
  - last_grant = DMA.
  - An interrupted write may leave that RAM word partially updated; requesters must restart after reset.

Decomposition:
- Shared package ext_ram_pkg:
  - State encoding: IDLE, LO, HI, DONE.
  - Port-id constants: PORT_CPU, PORT_DMA.
  - BYTE_CYCLES_MIN = 3.
- Sub-module ext_ram_byte_seq: phase counter, a0, registered we_b, byte sample strobes.
- ext_ram_arbiter: arbitration, latching, ack/rdata steering.

Test Plan:
- CPU read of addr 0x00010, RAM model bytes 0x34 at byte address 0x00020 and 0x12 at 0x00021 -> ram_addr 0x00020 for 4 cycles then 0x00021 for 4; cpu_ack 9 cycles after req; cpu_rdata = 0x1234; ram_we_b stays 1.
- DMA write 0xBEEF to addr 0x3FFFF -> byte address 0x7FFFE gets 0xEF and 0x7FFFF gets 0xBE. ram_we_b low exactly at counts 1-2 of each phase. ram_data stable from count 0 to 3. ram_addr never exceeds 0x7FFFF.
- CPU and DMA request in the same cycle, both held through repeated transfers -> grants alternate CPU, DMA, CPU, DMA. Each ack is a single cycle. The non-granted port's rdata is unchanged.
- Reset_b pulsed low at HI count 1 of a write -> same-cycle ram_we_b=1, ram_cs_b=1, ram_data Z, no ack. After release, the first tie is granted to the CPU.
- BYTE_CYCLES=3 build, CPU read then immediate CPU write -> ack at 7 cycles; one-cycle we_b pulse per byte; data bus never driven during the read; read data correct.
- cpu_addr/cpu_wdata changed mid-transfer -> RAM receives the originally latched values.

Source files
------------

// File: rtl/ext_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ext_ram_pkg
//  Description : Shared types and constants for the byte-wide external SRAM
//                arbiter: transfer state encoding, port identifiers and the
//                minimum legal byte-phase length.
//  Revision    : 1.0  initial release
// ============================================================================
package ext_ram_pkg;

    // Transfer sequencing: arbitrate, low byte, high byte, acknowledge
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } ram_state_t;

    // Requester identity, used for grant and round-robin history
    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_id_t;

    // A byte phase needs one setup cycle, at least one strobe cycle and one
    // hold cycle, so three cycles is the shortest workable phase.
    localparam int BYTE_CYCLES_MIN = 3;

    // Round-robin choice when both ports request: the port not served last
    function automatic port_id_t rr_pick(input logic cpu_req,
                                         input logic dma_req,
                                         input port_id_t last_grant);
        port_id_t pick;
        pick = PORT_CPU;
        if (cpu_req && dma_req) begin
            pick = (last_grant == PORT_CPU) ? PORT_DMA : PORT_CPU;
        end else if (dma_req) begin
            pick = PORT_DMA;
        end
        return pick;
    endfunction

endpackage : ext_ram_pkg
`default_nettype wire

// File: rtl/ext_ram_byte_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ext_ram_byte_seq
//  Description : Byte-phase timing for the external SRAM. Counts cycles within
//                each LO/HI phase, produces the byte-select address bit, a
//                registered write strobe and the end-of-phase sample strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module ext_ram_byte_seq
    import ext_ram_pkg::*;
#(
    parameter int BYTE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_b,
    input  ram_state_t state,
    input  logic       is_write,
    output logic       a0,
    output logic       we_b,
    output logic       sample_lo,
    output logic       sample_hi
);

    localparam int           CW      = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST    = CW'(BYTE_CYCLES - 1);
    // Last count at which the strobe for the following cycle is still low
    localparam logic [CW-1:0] WE_LAST = CW'(BYTE_CYCLES - 3);

    logic [CW-1:0] count;
    logic          active;
    logic          in_hi;
    logic          phase_last;

    assign active     = (state == LO) || (state == HI);
    assign in_hi      = (state == HI);
    assign phase_last = active && (count == LAST);
    assign sample_lo  = phase_last && !in_hi;
    assign sample_hi  = phase_last && in_hi;

    // Phase counter: 0..BYTE_CYCLES-1 inside LO and HI, parked at 0 elsewhere
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            count <= '0;
        end else if (!active || phase_last) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Byte select: set for the whole HI phase only
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            a0 <= 1'b0;
        end else begin
            a0 <= active && (in_hi ? !phase_last : phase_last);
        end
    end

    // Write strobe flop: low for counts 1..BYTE_CYCLES-2 of a write phase,
    // decided one cycle early so the pin comes straight from a register
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            we_b <= 1'b1;
        end else begin
            we_b <= !(active && is_write && (count <= WE_LAST));
        end
    end

endmodule : ext_ram_byte_seq
`default_nettype wire

// File: rtl/ext_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ext_ram_arbiter
//  Description : Round-robin arbiter sharing one byte-wide external SRAM
//                between a CPU port and a DMA port. Each 16-bit word access is
//                split into a low-byte and a high-byte phase; request fields
//                are latched at grant so requesters may not disturb a transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module ext_ram_arbiter
    import ext_ram_pkg::*;
#(
    parameter int BYTE_CYCLES = 4,
    parameter int ADDR_W      = 18
) (
    input  logic              clock,
    input  logic              reset_b,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_rnw,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [15:0]       dma_wdata,
    output logic              dma_ack,
    output logic [15:0]       dma_rdata,
    output logic              ram_cs_b,
    output logic              ram_oe_b,
    output logic              ram_we_b,
    output logic [ADDR_W:0]   ram_addr,
    inout  wire  [7:0]        ram_data
);

    ram_state_t        state;
    port_id_t          grant;
    port_id_t          last_grant;
    port_id_t          pick;
    logic              lat_rnw;
    logic [ADDR_W-1:0] lat_addr;
    logic [15:0]       lat_wdata;
    logic [7:0]        lo_byte;
    logic [7:0]        dout;
    logic              drive;
    logic              a0;
    logic              sample_lo;
    logic              sample_hi;
    logic              sel_rnw;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_wdata;

    // Byte-phase timing, strobe and byte select
    ext_ram_byte_seq #(
        .BYTE_CYCLES (BYTE_CYCLES)
    ) u_byte_seq (
        .clock     (clock),
        .reset_b   (reset_b),
        .state     (state),
        .is_write  (!lat_rnw),
        .a0        (a0),
        .we_b      (ram_we_b),
        .sample_lo (sample_lo),
        .sample_hi (sample_hi)
    );

    assign ram_addr = {lat_addr, a0};
    assign ram_data = drive ? dout : 8'hzz;

    // Arbitration choice and the request fields of the chosen port
    always_comb begin
        pick      = rr_pick(cpu_req, dma_req, last_grant);
        sel_rnw   = cpu_rnw;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (pick == PORT_DMA) begin
            sel_rnw   = dma_rnw;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
    end

    // Transfer FSM: grant/latch, byte steering, read capture and ack pulse
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state      <= IDLE;
            grant      <= PORT_CPU;
            last_grant <= PORT_DMA;
            lat_rnw    <= 1'b1;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lo_byte    <= '0;
            dout       <= '0;
            drive      <= 1'b0;
            ram_cs_b   <= 1'b1;
            ram_oe_b   <= 1'b1;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        state      <= LO;
                        grant      <= pick;
                        last_grant <= pick;
                        lat_rnw    <= sel_rnw;
                        lat_addr   <= sel_addr;
                        lat_wdata  <= sel_wdata;
                        ram_cs_b   <= 1'b0;
                        ram_oe_b   <= !sel_rnw;
                        drive      <= !sel_rnw;
                        dout       <= sel_wdata[7:0];
                    end
                end
                LO: begin
                    if (sample_lo) begin
                        state <= HI;
                        dout  <= lat_wdata[15:8];
                        if (lat_rnw) begin
                            lo_byte <= ram_data;
                        end
                    end
                end
                HI: begin
                    if (sample_hi) begin
                        state    <= DONE;
                        ram_cs_b <= 1'b1;
                        ram_oe_b <= 1'b1;
                        drive    <= 1'b0;
                        if (grant == PORT_CPU) begin
                            cpu_ack <= 1'b1;
                            if (lat_rnw) begin
                                cpu_rdata <= {ram_data, lo_byte};
                            end
                        end else begin
                            dma_ack <= 1'b1;
                            if (lat_rnw) begin
                                dma_rdata <= {ram_data, lo_byte};
                            end
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : ext_ram_arbiter
`default_nettype wire
